// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the decoupled instruction-fetch front end.
package fetch_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam int PC_STEP      = 4;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             instr;
    logic                    filled;
  } fetch_entry_t;

  // One extra bit over the index so that full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetched instructions: entries are allocated when a request
// is accepted and filled in order as responses return.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [31:0]     i_fill_instr,
  input  logic            i_pop,
  output logic [PW-1:0]   o_occ,
  output logic [PW-1:0]   o_inflight,
  output logic            o_head_filled,
  output logic [XLEN-1:0] o_head_pc,
  output logic [31:0]     o_head_instr
);
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]   r_head, r_alloc, r_fill;
  logic [IW-1:0]   w_head_idx, w_alloc_idx, w_fill_idx;
  logic [XLEN-1:0] w_pc_arr    [DEPTH];
  logic [31:0]     w_instr_arr [DEPTH];
  logic            w_filled_arr[DEPTH];

  assign w_head_idx  = r_head[IW-1:0];
  assign w_alloc_idx = r_alloc[IW-1:0];
  assign w_fill_idx  = r_fill[IW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
    end else begin
      if (i_alloc) r_alloc <= r_alloc + PTR_ONE;
      if (i_fill)  r_fill  <= r_fill + PTR_ONE;
      if (i_pop)   r_head  <= r_head + PTR_ONE;
    end
  end

  // Alloc, fill and pop never target the same entry in one cycle, so each
  // entry owns its registers and simply reacts to whichever pointer hits it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [IW-1:0] IDX = IW'(gi);
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_filled;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_pc     <= '0;
        r_instr  <= '0;
        r_filled <= 1'b0;
      end else if (i_flush) begin
        r_pc     <= '0;
        r_instr  <= '0;
        r_filled <= 1'b0;
      end else begin
        if (i_alloc && (w_alloc_idx == IDX)) begin
          r_pc     <= i_alloc_pc;
          r_filled <= 1'b0;
        end
        if (i_fill && (w_fill_idx == IDX)) begin
          r_instr  <= i_fill_instr;
          r_filled <= 1'b1;
        end
        if (i_pop && (w_head_idx == IDX)) r_filled <= 1'b0;
      end
    end

    assign w_pc_arr[gi]     = r_pc;
    assign w_instr_arr[gi]  = r_instr;
    assign w_filled_arr[gi] = r_filled;
  end

  assign o_occ         = r_alloc - r_head;
  assign o_inflight    = r_alloc - r_fill;
  assign o_head_filled = w_filled_arr[w_head_idx];
  assign o_head_pc     = w_pc_arr[w_head_idx];
  assign o_head_instr  = w_instr_arr[w_head_idx];
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: sequential PC generation, credit-limited request
// issue, in-order response buffering and redirect with in-flight drop tracking.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic            rsp_err
);
  localparam int              PW      = ptr_width(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [PW:0]     CREDITS = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_next_pc;
  logic [PW-1:0]   r_drop_cnt;
  logic            r_rsp_err, r_active;
  logic [PW-1:0]   w_occ, w_inflight, w_outstanding;
  logic [PW:0]     w_credits_used;
  logic            w_req_fire, w_fill, w_pop, w_head_filled, w_drop_nz;
  logic            w_unused_low_bits;

  assign w_unused_low_bits = &{1'b0, redirect_pc[1:0]};

  // Stale responses still owed by memory occupy credits just like live entries.
  assign w_credits_used = {1'b0, w_occ} + {1'b0, r_drop_cnt};
  assign w_outstanding  = r_drop_cnt + w_inflight;
  assign w_drop_nz      = (r_drop_cnt != '0);

  assign imem_req_valid = r_active && (w_credits_used < CREDITS) && !redirect_valid;
  assign imem_req_addr  = r_next_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_fill         = imem_rsp_valid && !redirect_valid && !w_drop_nz && (w_inflight != '0);
  assign fetch_valid    = w_head_filled && !redirect_valid;
  assign w_pop          = fetch_valid && fetch_ready;
  assign rsp_err        = r_rsp_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_next_pc  <= RESET_PC;
      r_drop_cnt <= '0;
      r_rsp_err  <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid) begin
        r_next_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
        // A response in the redirect cycle belongs to the old in-flight set.
        r_drop_cnt <= w_outstanding -
                      ((imem_rsp_valid && (w_outstanding != '0)) ? PTR_ONE : '0);
      end else begin
        if (w_req_fire) r_next_pc <= r_next_pc + STEP;
        if (imem_rsp_valid && w_drop_nz) r_drop_cnt <= r_drop_cnt - PTR_ONE;
      end
      if (imem_rsp_valid && (w_outstanding == '0)) r_rsp_err <= 1'b1;
    end
  end

  fetch_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock         (clock),
    .reset         (reset),
    .i_flush       (redirect_valid),
    .i_alloc       (w_req_fire),
    .i_alloc_pc    (r_next_pc),
    .i_fill        (w_fill),
    .i_fill_instr  (imem_rsp_data),
    .i_pop         (w_pop),
    .o_occ         (w_occ),
    .o_inflight    (w_inflight),
    .o_head_filled (w_head_filled),
    .o_head_pc     (fetch_pc),
    .o_head_instr  (fetch_instr)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model plus a transaction-level
// scoreboard of expected requests and decode entries, compared every cycle.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        rsp_err;

  always #5 clock = ~clock;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .rsp_err        (rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  acc_log[$];
  logic [31:0]  pop_log[$];
  int           checks = 0, failures = 0, cyc = 0, lat = 1;
  logic [31:0]  exp_addr = RESET_PC;
  bit           exp_active = 1'b0, exp_err = 1'b0, inj = 1'b0;
  bit           nx_redirect = 1'b0, nx_req_ready = 1'b0, nx_fetch_ready = 1'b0;
  logic [31:0]  nx_redirect_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, compare DUT to model, advance model at posedge.
  task automatic step();
    bit from_q, exp_rv, exp_fv;
    @(negedge clock);
    redirect_valid = nx_redirect;
    redirect_pc    = nx_redirect_pc;
    imem_req_ready = nx_req_ready;
    fetch_ready    = nx_fetch_ready;
    from_q = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      from_q = 1'b1;
    end else if (inj) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    exp_rv = exp_active && (mem_q.size() + exp_q.size() < DEPTH) && !redirect_valid;
    exp_fv = (exp_q.size() > 0) && !redirect_valid;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, exp_addr);
    chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    if (exp_q.size() > 0) begin
      chk("fetch_pc", fetch_pc, exp_q[0].pc);
      chk("fetch_instr", fetch_instr, exp_q[0].instr);
    end
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    @(posedge clock);
    cyc++;
    if (from_q) begin
      if (!redirect_valid && !mem_q[0].stale)
        exp_q.push_back(fetch_entry_t'{pc: mem_q[0].addr, instr: mem_word(mem_q[0].addr), filled: 1'b1});
      else
        $display("drop rsp addr=%h", mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (inj) begin
      exp_err = 1'b1;
      $display("spurious rsp injected");
    end
    if (redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      exp_addr = {redirect_pc[31:2], 2'b00};
      $display("redirect to %h", exp_addr);
    end else begin
      if (exp_fv && fetch_ready) begin
        pop_log.push_back(exp_q[0].pc);
        $display("pop pc=%h instr=%h", exp_q[0].pc, exp_q[0].instr);
        void'(exp_q.pop_front());
      end
      if (exp_rv && imem_req_ready) begin
        mem_q.push_back(mreq_t'{addr: exp_addr, due: cyc + lat - 1, stale: 1'b0});
        acc_log.push_back(exp_addr);
        $display("req addr=%h", exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; fetch_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    nx_redirect = 1'b0; nx_req_ready = 1'b0; nx_fetch_ready = 1'b0; inj = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_instr", fetch_instr, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    mem_q.delete(); exp_q.delete(); acc_log.delete(); pop_log.delete();
    exp_addr = RESET_PC; exp_err = 1'b0; exp_active = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    exp_active = 1'b1;
  endtask

  initial begin
    int a0, p0;

    // Streaming with 1-cycle memory
    do_reset();
    lat = 1; nx_req_ready = 1'b1; nx_fetch_ready = 1'b1;
    run(12);
    chk("stream_pops", 32'(pop_log.size()), 32'd10);
    chk("stream_first_pc", pop_log[0], 32'h0);
    chk("stream_last_pc", pop_log[9], 32'h24);

    // Full buffer, then one pop frees one credit
    do_reset();
    nx_req_ready = 1'b1; nx_fetch_ready = 1'b0;
    run(8);
    chk("full_accepts", 32'(acc_log.size()), 32'd4);
    chk("full_last_addr", acc_log[3], 32'hC);
    nx_fetch_ready = 1'b1;
    run(1);
    nx_fetch_ready = 1'b0;
    run(3);
    chk("credit_accepts", 32'(acc_log.size()), 32'd5);
    chk("credit_addr", acc_log[4], 32'h10);

    // Latency 3, redirect with 3 in flight and a response in the same cycle
    do_reset();
    lat = 3; nx_req_ready = 1'b1; nx_fetch_ready = 1'b0;
    run(3);
    nx_req_ready = 1'b0; nx_redirect = 1'b1; nx_redirect_pc = 32'h0000_0103;
    run(1);
    nx_redirect = 1'b0; nx_req_ready = 1'b1; nx_fetch_ready = 1'b1;
    run(14);
    chk("redir_req_addr", acc_log[3], 32'h100);
    chk("redir_first_pop", pop_log[0], 32'h100);

    // Back-to-back redirects during a stream with pending decode entries
    do_reset();
    lat = 2; nx_req_ready = 1'b1; nx_fetch_ready = 1'b1;
    run(8);
    a0 = acc_log.size(); p0 = pop_log.size();
    nx_redirect = 1'b1; nx_redirect_pc = 32'h0000_0200;
    run(1);
    nx_redirect_pc = 32'h0000_0302;
    run(1);
    nx_redirect = 1'b0;
    run(10);
    chk("b2b_req_addr", acc_log[a0], 32'h300);
    chk("b2b_first_pop", pop_log[p0], 32'h300);

    // Stalled request channel and PC wrap
    nx_req_ready = 1'b0; nx_redirect = 1'b1; nx_redirect_pc = 32'hFFFF_FFFC;
    run(1);
    nx_redirect = 1'b0;
    run(5);
    a0 = acc_log.size();
    nx_req_ready = 1'b1;
    run(6);
    chk("wrap_addr0", acc_log[a0], 32'hFFFF_FFFC);
    chk("wrap_addr1", acc_log[a0+1], 32'h0);

    // Spurious response with nothing outstanding
    nx_req_ready = 1'b0; nx_fetch_ready = 1'b0;
    for (int k = 0; k < 10 && mem_q.size() > 0; k++) step();
    inj = 1'b1;
    run(1);
    inj = 1'b0;
    run(3);
    chk("err_model", 32'(exp_err), 32'd1);
    nx_fetch_ready = 1'b1;
    run(6);

    do_reset();
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
